// File: rtl/mask_pattern_pkg.sv
// Shared constants, timing helpers and FSM encoding for mask_pattern_gen.
// Optional feature macro: MASK_PATTERN_MOVE_EN (see mask_pattern_gen.sv).
package mask_pattern_pkg;

   localparam int unsigned POS_W = 11;

   localparam int unsigned DEF_H_ACTIVE = 64;
   localparam int unsigned DEF_H_FP     = 4;
   localparam int unsigned DEF_H_SYNC   = 8;
   localparam int unsigned DEF_H_BP     = 4;
   localparam int unsigned DEF_V_ACTIVE = 48;
   localparam int unsigned DEF_V_FP     = 2;
   localparam int unsigned DEF_V_SYNC   = 2;
   localparam int unsigned DEF_V_BP     = 2;

   // Total period of a line (in clocks) or frame (in lines)
   function automatic int unsigned calc_total(input int unsigned act, input int unsigned fp,
                                              input int unsigned sync, input int unsigned bp);
      return act + fp + sync + bp;
   endfunction

   // Increment a column and wrap it into [0, modulus)
   function automatic logic [POS_W-1:0] wrap_inc(input logic [POS_W-1:0] x,
                                                 input int unsigned modulus);
      return POS_W'((32'(x) + 32'd1) % modulus);
   endfunction

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/mask_pattern_gen_timing.sv
// video_timing_counter: hc/vc raster counters with wrap and end-of-frame strobe.
module video_timing_counter
   import mask_pattern_pkg::*;
#(
   parameter int unsigned H_TOTAL = 80,
   parameter int unsigned V_TOTAL = 54
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_run,
   output logic [POS_W-1:0] o_hc,
   output logic [POS_W-1:0] o_vc,
   output logic             o_eof_c
);

   localparam logic [POS_W-1:0] L_H_LAST = POS_W'(H_TOTAL - 1);
   localparam logic [POS_W-1:0] L_V_LAST = POS_W'(V_TOTAL - 1);

   logic [POS_W-1:0] r_hc;
   logic [POS_W-1:0] r_vc;
   logic             w_h_last;
   logic             w_v_last;

   assign w_h_last = (r_hc == L_H_LAST);
   assign w_v_last = (r_vc == L_V_LAST);

   // Counters advance only while running; held at zero otherwise
   always_ff @(posedge clk) begin
      if (rst || !i_run) begin
         r_hc <= '0;
         r_vc <= '0;
      end else if (w_h_last) begin
         r_hc <= '0;
         r_vc <= w_v_last ? '0 : r_vc + POS_W'(1);
      end else begin
         r_hc <= r_hc + POS_W'(1);
      end
   end

   assign o_hc    = r_hc;
   assign o_vc    = r_vc;
   assign o_eof_c = i_run && w_h_last && w_v_last;

endmodule

// File: rtl/mask_pattern_gen.sv
// mask_pattern_gen: synthetic video source with de/h_sync/v_sync and a
// one-rectangle binary mask. Define MASK_PATTERN_MOVE_EN to make the
// rectangle step one column right (wrapping) every frame.
module mask_pattern_gen
   import mask_pattern_pkg::*;
#(
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned H_FP     = DEF_H_FP,
   parameter int unsigned H_SYNC   = DEF_H_SYNC,
   parameter int unsigned H_BP     = DEF_H_BP,
   parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
   parameter int unsigned V_FP     = DEF_V_FP,
   parameter int unsigned V_SYNC   = DEF_V_SYNC,
   parameter int unsigned V_BP     = DEF_V_BP
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [POS_W-1:0] rect_x0,
   input  logic [POS_W-1:0] rect_x1,
   input  logic [POS_W-1:0] rect_y0,
   input  logic [POS_W-1:0] rect_y1,
   output logic             de,
   output logic             h_sync,
   output logic             v_sync,
   output logic             mask,
   output logic [POS_W-1:0] x_pos,
   output logic [POS_W-1:0] y_pos,
   output logic             frame_start,
   output logic             busy
);

   localparam int unsigned H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int unsigned V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   localparam logic [POS_W-1:0] L_HA  = POS_W'(H_ACTIVE);
   localparam logic [POS_W-1:0] L_HS0 = POS_W'(H_ACTIVE + H_FP);
   localparam logic [POS_W-1:0] L_HS1 = POS_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [POS_W-1:0] L_VA  = POS_W'(V_ACTIVE);
   localparam logic [POS_W-1:0] L_VS0 = POS_W'(V_ACTIVE + V_FP);
   localparam logic [POS_W-1:0] L_VS1 = POS_W'(V_ACTIVE + V_FP + V_SYNC);

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_load;
   logic             w_reload;
   logic             w_run;
   logic             w_eof_c;
   logic [POS_W-1:0] w_hc;
   logic [POS_W-1:0] w_vc;

   logic [POS_W-1:0] r_x0;
   logic [POS_W-1:0] r_x1;
   logic [POS_W-1:0] r_y0;
   logic [POS_W-1:0] r_y1;

   logic             w_de;
   logic             w_hs;
   logic             w_vs;
   logic             w_mask;
   logic             w_fs;

   logic             r_de;
   logic             r_hs;
   logic             r_vs;
   logic             r_mask;
   logic [POS_W-1:0] r_x_pos;
   logic [POS_W-1:0] r_y_pos;
   logic             r_fs;
   logic             r_busy;

   assign w_run = (r_state == RUN);

   video_timing_counter #(
      .H_TOTAL (H_TOTAL),
      .V_TOTAL (V_TOTAL)
   ) u_timing (
      .clk     (clk),
      .rst     (rst),
      .i_run   (w_run),
      .o_hc    (w_hc),
      .o_vc    (w_vc),
      .o_eof_c (w_eof_c)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next state; enable is only looked at on a frame boundary
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_reload    = 1'b0;
      case (r_state)
         IDLE: begin
            if (enable) begin
               w_state_nxt = RUN;
               w_load      = 1'b1;
            end
         end
         RUN: begin
            if (w_eof_c) begin
               if (enable) w_reload    = 1'b1;
               else        w_state_nxt = IDLE;
            end
         end
      endcase
   end

   // Rectangle shadow registers, updated only at frame boundaries
   always_ff @(posedge clk) begin
      if (rst) begin
         r_x0 <= '0;
         r_x1 <= '0;
         r_y0 <= '0;
         r_y1 <= '0;
      end else if (w_load) begin
         r_x0 <= rect_x0;
         r_x1 <= rect_x1;
         r_y0 <= rect_y0;
         r_y1 <= rect_y1;
      end else if (w_reload) begin
`ifdef MASK_PATTERN_MOVE_EN
         r_x0 <= wrap_inc(r_x0, H_ACTIVE);
         r_x1 <= wrap_inc(r_x1, H_ACTIVE);
`else
         r_x0 <= rect_x0;
         r_x1 <= rect_x1;
`endif
         r_y0 <= rect_y0;
         r_y1 <= rect_y1;
      end
   end

   // Raster decode; an inverted rectangle fails both compares and stays empty
   always_comb begin
      w_de   = w_run && (w_hc < L_HA) && (w_vc < L_VA);
      w_hs   = w_run && (w_hc >= L_HS0) && (w_hc < L_HS1);
      w_vs   = w_run && (w_vc >= L_VS0) && (w_vc < L_VS1);
      w_mask = w_de && (w_hc >= r_x0) && (w_hc <= r_x1) &&
                       (w_vc >= r_y0) && (w_vc <= r_y1);
      w_fs   = w_de && (w_hc == '0) && (w_vc == '0);
   end

   // Single output register stage keeps every output cycle-aligned
   always_ff @(posedge clk) begin
      if (rst) begin
         r_de    <= 1'b0;
         r_hs    <= 1'b0;
         r_vs    <= 1'b0;
         r_mask  <= 1'b0;
         r_x_pos <= '0;
         r_y_pos <= '0;
         r_fs    <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_de    <= w_de;
         r_hs    <= w_hs;
         r_vs    <= w_vs;
         r_mask  <= w_mask;
         r_x_pos <= w_de ? w_hc : '0;
         r_y_pos <= w_de ? w_vc : '0;
         r_fs    <= w_fs;
         r_busy  <= w_run;
      end
   end

   assign de          = r_de;
   assign h_sync      = r_hs;
   assign v_sync      = r_vs;
   assign mask        = r_mask;
   assign x_pos       = r_x_pos;
   assign y_pos       = r_y_pos;
   assign frame_start = r_fs;
   assign busy        = r_busy;

endmodule

// File: doc/mask_pattern_gen.md
Name: mask_pattern_gen

Overview:
Transmitter end of the video stream interface consumed by the centroid block. Generates de, h_sync and v_sync timing plus a binary mask containing one programmable solid rectangle. Used as a synthetic source for bring-up and for self-checking the centroid path in simulation and on hardware without a camera.

Parameters:
H_ACTIVE, 64, active pixels per line
H_FP, 4, horizontal front porch, in clocks
H_SYNC, 8, h_sync width, in clocks
H_BP, 4, horizontal back porch, in clocks
V_ACTIVE, 48, active lines per frame
V_FP, 2, vertical front porch, in lines
V_SYNC, 2, v_sync width, in lines
V_BP, 2, vertical back porch, in lines
POS_W, 11, width of the coordinate ports and counters

Ports:
clk  in  1  clock; one pixel per cycle
rst  in  1  synchronous reset, active-high
enable  in  1  run request; sampled only at frame boundaries
rect_x0  in  POS_W  rectangle left column, inclusive
rect_x1  in  POS_W  rectangle right column, inclusive
rect_y0  in  POS_W  rectangle top line, inclusive
rect_y1  in  POS_W  rectangle bottom line, inclusive
de  out  1  active pixel
h_sync  out  1  horizontal sync, active-high
v_sync  out  1  vertical sync, active-high
mask  out  1  pixel inside rectangle, qualified by de
x_pos  out  POS_W  active column; 0 outside active
y_pos  out  POS_W  active line; 0 outside active
frame_start  out  1  one-cycle pulse on pixel (0,0)
busy  out  1  generator running

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL is defined the same way.
- hc counts 0..H_TOTAL-1 and wraps. vc increments when hc wraps and itself wraps at V_TOTAL-1.
- Line order: active [0, H_ACTIVE), front porch, sync, back porch. The frame uses the same order in lines.
- de = (hc < H_ACTIVE) && (vc < V_ACTIVE).
- h_sync = 1 for hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC) on every line, including blanking lines.
- v_sync = 1 for the whole of lines vc in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- mask = de && x0 <= hc <= x1 && y0 <= vc <= y1, all compares unsigned. If x0 > x1 or y0 > y1, mask stays 0 for the whole frame.
- All outputs are registered in one stage from hc/vc, so every output is mutually cycle-aligned. Latency from the counter value to the outputs is 1 clk.
- FSM states:
  - IDLE: counters held at 0, all outputs 0.
  - RUN: counters advance.
  - IDLE->RUN on enable=1. The rect_* inputs are latched into shadow registers on the same edge.
  - RUN->RUN at end of frame (hc=H_TOTAL-1, vc=V_TOTAL-1) while enable=1. The shadow registers reload at that edge.
  - RUN->IDLE at end of frame while enable=0. The current frame always completes.
- rect_* changes mid-frame have no effect until the next frame boundary.
- busy = 1 in RUN.
- frame_start = 1 for exactly one cycle, aligned with de on pixel (0,0).
- rst takes priority over every other event, from either state. It forces IDLE, zeroes the counters and shadow registers, and drives all outputs to 0 on the next cycle. A rst mid-frame truncates the frame with no further sync pulses.

Optional Feature:
MASK_PATTERN_MOVE_EN
- Defined: at each frame boundary in RUN, the latched x0 and x1 each get +1 added, modulo H_ACTIVE. The rect_x* inputs are reloaded only on IDLE->RUN. A rectangle whose x0 wraps past x1 renders empty for that frame.
- Undefined: the rectangle is static per frame, reloaded from rect_* at every frame boundary.

Decomposition:
- Package mask_pattern_pkg holds:
  - POS_W
  - default timing constants
  - the H_TOTAL/V_TOTAL derivation functions
  - the FSM state encoding (IDLE, RUN)
- Sub-module video_timing_counter holds the hc/vc counters with wrap and end-of-frame strobe. The top level holds the FSM, shadow registers, compares and output registers.

Test Plan:
- Reset, then enable=1 with rect (10,19,5,8) on the default timing:
  - de high for 64 clocks per line, on 48 lines.
  - 40 mask cycles per frame.
  - The centroid path reads x=14, y=6.
- Per-frame period and sync placement:
  - Period between frame_start pulses = 80×54 = 4320 clocks.
  - h_sync rises 68 clocks after the line start and lasts 8.
  - v_sync lasts 160 clocks.
- rect_x0 changed to 30 mid-frame: the mask column is unchanged until the next frame_start, then starts at 30.
- enable dropped at line 20: the frame completes, busy falls after the last back-porch cycle, and all outputs stay 0.
- Empty rect x0=20 > x1=10: mask=0 for the entire frame while de and syncs stay normal.
- rst asserted mid-line during RUN: every output is 0 on the next cycle, with no further frame_start.
- With MASK_PATTERN_MOVE_EN defined and rect (62,63,0,0): the next frame starts mask at x=63 and x=0 (wrapped) and renders empty.
